// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, control/immediate encodings, ID/EX record and decode helpers
// Contents:
//   OP_*          RV32I major opcodes handled by the decode stage
//   imm_src_e     immediate format selector
//   alu_ctrl_e    ALU operation encoding driven to execute
//   ctrl_t        decoded control bundle for one instruction
//   id_ex_t       control and register-field half of the ID/EX register
//   ctrl_decode() main + ALU control decoder
//   imm_ext()     sign-extension of the selected immediate format
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam int REG_FIELD_W = 5;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic      reg_write;
        logic      alu_src;
        logic      mem_write;
        logic      result_src;
        logic      branch;
        imm_src_e  imm_src;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

    // XLEN-wide operands live beside this record in the stage itself so the
    // package stays independent of the datapath width.
    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic                   alu_src;
        logic                   mem_write;
        logic                   result_src;
        logic                   branch;
        alu_ctrl_e              alu_ctrl;
        logic [REG_FIELD_W-1:0] rd;
        logic [REG_FIELD_W-1:0] rs1;
        logic [REG_FIELD_W-1:0] rs2;
    } id_ex_t;

    // Unknown opcodes decode to all-zero controls, i.e. a harmless nop.
    // R-type leaves imm_src at IMM_I; its immediate is a don't-care.
    function automatic ctrl_t ctrl_decode(input logic [31:0] instr);
        ctrl_t      c;
        logic [1:0] alu_op;
        logic [2:0] f3;
        c      = '0;
        alu_op = 2'b00;
        f3     = instr[14:12];
        case (instr[6:0])
            OP_LOAD:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = 1'b1; end
            OP_STORE:  begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.imm_src = IMM_S; end
            OP_RTYPE:  begin c.reg_write = 1'b1; alu_op = 2'b10; end
            OP_BRANCH: begin c.branch = 1'b1; c.imm_src = IMM_B; alu_op = 2'b01; end
            OP_ITYPE:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; alu_op = 2'b10; end
            default:   ;
        endcase
        // funct7[5] selects sub only for R-type; addi with imm[10]=1 stays add.
        c.alu_ctrl = alu_op == 2'b00 ? ALU_ADD :
                     alu_op == 2'b01 ? ALU_SUB :
                     f3 == 3'b000    ? ((instr[5] & instr[30]) ? ALU_SUB : ALU_ADD) :
                     f3 == 3'b010    ? ALU_SLT :
                     f3 == 3'b110    ? ALU_OR  :
                     f3 == 3'b111    ? ALU_AND : ALU_ADD;
        return c;
    endfunction

    function automatic logic [31:0] imm_ext(input logic [31:0] i, input imm_src_e s);
        return s == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
               s == IMM_B ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
               s == IMM_J ? {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0} :
                            {{20{i[31]}}, i[31:20]};
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: NUM_REGS x XLEN register file, two async read ports, one write port
// Ports:
//   clk, rst        clock, synchronous active-high clear of every entry
//   i_we/i_wa/i_wd  write enable, address, data (writes to x0 are dropped)
//   i_ra1/i_ra2     read addresses
//   o_rd1/o_rd2     read data (x0 always reads 0)
// Macro DECODE_WB_BYPASS_EN: a read of the address being written this cycle
// returns i_wd instead of the stored value.
module regfile_bypass #(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd,
    input  logic [AW-1:0]   i_ra1,
    input  logic [AW-1:0]   i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] r_mem [NUM_REGS];
    logic            w_wr;

    assign w_wr = i_we & (i_wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[i_wa] <= i_wd;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    assign o_rd1 = (i_ra1 == '0) ? '0 : (w_wr && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : (w_wr && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
`else
    assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
`endif

endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: handshaked decode stage with register file, load-use interlock and ID/EX register
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ValidD/ReadyD                 fetch-side handshake for InstrD, PCD, PCPlus4D
//   ReadyE                        execute accepts the ID/EX contents
//   Flush                         redirect: kill decode and ID/EX
//   RegWriteW/RDW/ResultW         writeback port into the register file
//   ValidE, *E, *_E               registered ID/EX contents
//   LoadUseStall                  load-use interlock active this cycle
// Macro DECODE_WB_BYPASS_EN: writeback forwards into the same-cycle read;
// otherwise decode waits one cycle when it reads a register being written.
module decode_stage_hs
    import riscv_pkg::*;
#(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidD,
    output logic            ReadyD,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ReadyE,
    input  logic            Flush,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic [AW-1:0]   RD_E,
    output logic [AW-1:0]   RS1_E,
    output logic [AW-1:0]   RS2_E,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic            LoadUseStall
);

    ctrl_t           w_ctrl;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic            w_load_use;
    logic            w_wb_conflict;
    logic            w_advance;
    logic            w_load;

    id_ex_t          r_ex;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;

    assign w_ctrl  = ctrl_decode(InstrD);
    assign w_imm32 = imm_ext(InstrD, w_ctrl.imm_src);
    assign w_imm   = XLEN'($signed(w_imm32));
    assign w_rs1   = InstrD[15 +: AW];
    assign w_rs2   = InstrD[20 +: AW];

    regfile_bypass #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_we  (RegWriteW),
        .i_wa  (RDW),
        .i_wd  (ResultW),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    // Both source fields are compared whatever the format; a false match on
    // an immediate field only costs one bubble.
    assign w_load_use = ValidE & ResultSrcE & RegWriteE & (RD_E != '0) &
                        ((RD_E == w_rs1) | (RD_E == w_rs2));

`ifdef DECODE_WB_BYPASS_EN
    assign w_wb_conflict = 1'b0;
`else
    assign w_wb_conflict = RegWriteW & (RDW != '0) & ((RDW == w_rs1) | (RDW == w_rs2));
`endif

    assign w_advance    = ~ValidE | ReadyE;
    assign ReadyD       = Flush | (w_advance & ~w_load_use & ~w_wb_conflict);
    assign w_load       = w_advance & ValidD & ~w_load_use & ~w_wb_conflict;
    assign LoadUseStall = ValidD & w_load_use & ~Flush;

    // Flush and bubbles clear only valid and side-effecting controls; the
    // data fields keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_rd1 <= '0;
            r_rd2 <= '0;
            r_imm <= '0;
            r_pc  <= '0;
            r_pc4 <= '0;
        end else if (w_load & ~Flush) begin
            r_ex  <= '{valid:      1'b1,
                       reg_write:  w_ctrl.reg_write,
                       alu_src:    w_ctrl.alu_src,
                       mem_write:  w_ctrl.mem_write,
                       result_src: w_ctrl.result_src,
                       branch:     w_ctrl.branch,
                       alu_ctrl:   w_ctrl.alu_ctrl,
                       rd:         InstrD[11:7],
                       rs1:        InstrD[19:15],
                       rs2:        InstrD[24:20]};
            r_rd1 <= w_rd1;
            r_rd2 <= w_rd2;
            r_imm <= w_imm;
            r_pc  <= PCD;
            r_pc4 <= PCPlus4D;
        end else if (Flush | w_advance) begin
            r_ex.valid      <= 1'b0;
            r_ex.reg_write  <= 1'b0;
            r_ex.mem_write  <= 1'b0;
            r_ex.result_src <= 1'b0;
            r_ex.branch     <= 1'b0;
        end
    end

    assign ValidE      = r_ex.valid;
    assign RegWriteE   = r_ex.reg_write;
    assign ALUSrcE     = r_ex.alu_src;
    assign MemWriteE   = r_ex.mem_write;
    assign ResultSrcE  = r_ex.result_src;
    assign BranchE     = r_ex.branch;
    assign ALUControlE = r_ex.alu_ctrl;
    assign RD_E        = r_ex.rd[AW-1:0];
    assign RS1_E       = r_ex.rs1[AW-1:0];
    assign RS2_E       = r_ex.rs2[AW-1:0];
    assign RD1_E       = r_rd1;
    assign RD2_E       = r_rd2;
    assign Imm_Ext_E   = r_imm;
    assign PCE         = r_pc;
    assign PCPlus4E    = r_pc4;

endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs: scoreboard bench for decode_stage_hs with directed instruction vectors
module tb_decode_stage_hs;

    typedef struct packed {
        logic        rw, as, mw, rs, br;
        logic [2:0]  alu;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] rd1, rd2, imm, pc, pc4;
    } exp_t;

`ifdef DECODE_WB_BYPASS_EN
    localparam int WB_WAIT = 0;
`else
    localparam int WB_WAIT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ValidD = 1'b0;
    logic [31:0] InstrD = '0;
    logic [31:0] PCD = '0;
    logic [31:0] PCPlus4D = '0;
    logic        ReadyE = 1'b1;
    logic        Flush = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RDW = '0;
    logic [31:0] ResultW = '0;
    logic        ReadyD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, LoadUseStall;
    logic [2:0]  ALUControlE;
    logic [4:0]  RD_E, RS1_E, RS2_E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;

    exp_t act;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    decode_stage_hs dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .ReadyD(ReadyD), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ReadyE(ReadyE), .Flush(Flush),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .ValidE(ValidE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .LoadUseStall(LoadUseStall)
    );

    always #5 clk = ~clk;

    assign act = {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                  RD_E, RS1_E, RS2_E, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E};

    function automatic exp_t mk(logic rw, logic as, logic mw, logic rs, logic br, logic [2:0] alu,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm, logic [31:0] pc);
        return '{rw, as, mw, rs, br, alu, rd, rs1, rs2, rd1, rd2, imm, pc, pc + 32'd4};
    endfunction

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every E-side transfer must match the oldest accepted instruction.
    always @(negedge clk) begin
        if (!rst && ValidE && ReadyE) begin
            if (sb.size() == 0) chk("unexpected_issue", ValidE, 0);
            else chk("e_stage", act, sb.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input exp_t e, input bit push,
                         output int waits, output bit lus0, output bit v1);
        bit acc;
        acc = 1'b0;
        waits = 0;
        lus0 = 1'b0;
        v1 = 1'b0;
        InstrD = ins;
        PCD = pc;
        PCPlus4D = pc + 32'd4;
        ValidD = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) lus0 = LoadUseStall;
            if (k == 1) v1 = ValidE | RegWriteE;
            acc = ReadyD;
            if (acc && push) sb.push_back(e);
            @(posedge clk);
            #1;
            RegWriteW = 1'b0;
            if (acc) break;
            waits++;
        end
        ValidD = 1'b0;
        chk("issue_accept", acc, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit l, v;
        exp_t dummy;
        dummy = '0;
        ValidD = 1'b1;
        InstrD = 32'h00500093;
        repeat (3) begin
            @(negedge clk);
            chk("reset_zero", |{act, ValidE, LoadUseStall}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ValidD = 1'b0;
        RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'd5;
        @(posedge clk); #1;
        RegWriteW = 1'b0;

        issue(32'h00500093, 32'h100, mk(1,1,0,0,0,3'd0, 5'd1,5'd0,5'd5, 32'd0,32'd0,32'd5, 32'h100), 1, w, l, v);
        chk("addi_wait", w, 0);

        issue(32'h0000A103, 32'h104, mk(1,1,0,1,0,3'd0, 5'd2,5'd1,5'd0, 32'd5,32'd0,32'd0, 32'h104), 1, w, l, v);
        chk("lw_wait", w, 0);
        issue(32'h001101B3, 32'h108, mk(1,0,0,0,0,3'd0, 5'd3,5'd2,5'd1, 32'd0,32'd5,32'd1, 32'h108), 1, w, l, v);
        chk("loaduse_wait", w, 1);
        chk("loaduse_flag", l, 1);
        chk("loaduse_bubble", v, 0);

        ReadyE = 1'b0;
        ValidD = 1'b1; InstrD = 32'h00700213; PCD = 32'h10C; PCPlus4D = 32'h110;
        repeat (3) begin
            @(negedge clk);
            chk("hold_ready", ReadyD, 0);
            chk("hold_e", {ValidE, RD_E, PCE}, {1'b1, 5'd3, 32'h108});
            @(posedge clk); #1;
        end
        ReadyE = 1'b1;
        issue(32'h00700213, 32'h10C, mk(1,1,0,0,0,3'd0, 5'd4,5'd0,5'd7, 32'd0,32'd0,32'd7, 32'h10C), 1, w, l, v);
        chk("release_wait", w, 0);

        issue(32'h00100393, 32'h110, dummy, 0, w, l, v);
        ReadyE = 1'b0;
        ValidD = 1'b1; InstrD = 32'h00900313; PCD = 32'h114; PCPlus4D = 32'h118;
        Flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", ReadyD, 1);
        @(posedge clk); #1;
        Flush = 1'b0;
        ValidD = 1'b0;
        @(negedge clk);
        chk("flush_kill", {ValidE, RegWriteE, RD_E}, {1'b0, 1'b0, 5'd7});
        @(posedge clk); #1;
        ReadyE = 1'b1;

        RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEADBEEF;
        issue(32'h00028413, 32'h118, mk(1,1,0,0,0,3'd0, 5'd8,5'd5,5'd0, 32'hDEADBEEF,32'd0,32'd0, 32'h118), 1, w, l, v);
        chk("wb_wait", w, WB_WAIT);

        issue(32'h0050A423, 32'h11C, mk(0,1,1,0,0,3'd0, 5'd8,5'd1,5'd5, 32'd5,32'hDEADBEEF,32'd8, 32'h11C), 1, w, l, v);
        issue(32'hFE208EE3, 32'h120, mk(0,0,0,0,1,3'd1, 5'd29,5'd1,5'd2, 32'd5,32'd0,32'hFFFFFFFC, 32'h120), 1, w, l, v);
        issue(32'h0050E533, 32'h124, mk(1,0,0,0,0,3'd3, 5'd10,5'd1,5'd5, 32'd5,32'hDEADBEEF,32'd5, 32'h124), 1, w, l, v);

        RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h1234;
        issue(32'h00000493, 32'h128, mk(1,1,0,0,0,3'd0, 5'd9,5'd0,5'd0, 32'd0,32'd0,32'd0, 32'h128), 1, w, l, v);
        chk("x0_wait", w, 0);
        issue(32'h000006B3, 32'h12C, mk(1,0,0,0,0,3'd0, 5'd13,5'd0,5'd0, 32'd0,32'd0,32'd0, 32'h12C), 1, w, l, v);

        @(posedge clk); #1;
        ReadyE = 1'b0;
        issue(32'h00100393, 32'h130, dummy, 0, w, l, v);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_zero", |{act, ValidE}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ReadyE = 1'b1;
        issue(32'h00008593, 32'h140, mk(1,1,0,0,0,3'd0, 5'd11,5'd1,5'd0, 32'd0,32'd0,32'd0, 32'h140), 1, w, l, v);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
